// File: rtl/ama_riscv_fetch.sv
// ============================================================================
// Module   : ama_riscv_fetch
// Brief    : Instruction fetch unit. Owns the fetch PC, issues word requests
//            to instruction memory, buffers {inst, pc} responses in a small
//            FIFO and hands them to decode over a valid/ready handshake.
//            Redirects (flush) discard buffered and in-flight instructions.
//            Optional macro FETCH_PERF_CNT_EN adds the stall_cnt counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VEC  = 32'h4000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_dec,
  output logic [31:0] pc_dec,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = AW + 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   req_pc;      // address of the request currently in flight
  logic [31:0]   last_pc;     // last PC shown to decode, held while empty
  logic          inflight;
  logic          drop;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          accept;
  logic [CW-1:0] occupancy;

  // Credit check, request issue and decode-side view of the FIFO head
  always_comb begin
    inst_valid = (count != '0);
    pop        = inst_valid && dec_ready;
    // Entries already held plus the one that may land next cycle, minus the
    // one leaving now: a request is only sent if its response has a slot.
    occupancy  = count + CW'(inflight) - CW'(pop);
    imem_req   = !rst && !flush && (occupancy < DEPTH_C);
    imem_addr  = pc;
    accept     = imem_req && imem_rdy;
    // Responses only count if they belong to a live request; this also
    // discards anything returned for a request that was cut off by reset.
    push       = imem_rsp_valid && inflight && !drop && !flush;
    inst_dec   = inst_valid ? fifo_inst[rd_ptr] : NOP;
    pc_dec     = inst_valid ? fifo_pc[rd_ptr]   : last_pc;
  end

  // Fetch PC, in-flight tracking and stale-response drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_VEC;
      req_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= accept;
      drop     <= flush && inflight;
      if (accept) begin
        req_pc <= pc;
      end
      if (flush) begin
        pc <= {flush_pc[31:2], 2'b00};
      end else if (accept) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // FIFO pointers and occupancy; a flush empties the buffer outright
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: data and the exact address it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

  // Remember the last presented PC so pc_dec holds while the FIFO is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc <= '0;
    end else if (inst_valid) begin
      last_pc <= fifo_pc[rd_ptr];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Cycles where decode wanted an instruction but fetch had none to give
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (dec_ready && !inst_valid && !flush) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // The credit rule makes a push into a full FIFO unreachable
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && (count == DEPTH_C)));

endmodule

`default_nettype wire

// File: tb/tb_ama_riscv_fetch.sv
// ============================================================================
// Module   : tb_ama_riscv_fetch
// Brief    : Self-checking bench for ama_riscv_fetch with a queue-based
//            behavioural model and a memory that returns addr ^ 32'hA5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ama_riscv_fetch;

  localparam logic [31:0] RV    = 32'h4000_0000;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst_dec;
  logic [31:0] pc_dec;
  logic        inst_valid;
  logic        dec_ready;
  logic        flush;
  logic [31:0] flush_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ama_riscv_fetch #(
    .RESET_VEC (RV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdy      (imem_rdy),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_dec      (inst_dec),
    .pc_dec        (pc_dec),
    .inst_valid    (inst_valid),
    .dec_ready     (dec_ready),
    .flush         (flush),
    .flush_pc      (flush_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  // Behavioural model: a queue of {pc, inst} plus the fetch PC and the
  // single outstanding request.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  logic [31:0] m_last_pc;
  logic [31:0] m_stall;
  bit          m_infl;
  bit          m_drop;
  bit          dut_acc;
  logic [31:0] dut_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc       = RV;
    m_req_addr = '0;
    m_last_pc  = '0;
    m_stall    = '0;
    m_infl     = 1'b0;
    m_drop     = 1'b0;
  endtask

  function automatic bit exp_req();
    int pop;
    pop = (q.size() != 0 && dec_ready) ? 1 : 0;
    return !flush && ((q.size() + int'(m_infl) - pop) < DEPTH);
  endfunction

  task automatic compare();
    bit er;
    er = exp_req();
    check("imem_req", 32'(imem_req), 32'(er));
    if (er) check("imem_addr", imem_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
    check("inst_dec", inst_dec, (q.size() != 0) ? q[0][31:0] : NOP);
    check("pc_dec", pc_dec, (q.size() != 0) ? q[0][63:32] : m_last_pc);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    dut_acc  = imem_req && imem_rdy;
    dut_addr = imem_addr;
  endtask

  // Advance the model by one clock using the inputs present before the edge
  task automatic model_step();
    bit          valid;
    bit          pop;
    bit          acc;
    logic [31:0] old_pc;
    valid  = (q.size() != 0);
    pop    = valid && dec_ready;
    acc    = exp_req() && imem_rdy;
    old_pc = m_pc;
    if (dec_ready && !valid && !flush) m_stall = m_stall + 1;
    if (valid) m_last_pc = q[0][63:32];
    if (flush) begin
      q.delete();
      m_pc = {flush_pc[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (imem_rsp_valid && m_infl && !m_drop) q.push_back({m_req_addr, imem_rsp_data});
      if (acc) m_pc = m_pc + 32'd4;
    end
    m_drop = flush && m_infl;
    m_infl = acc;
    if (acc) m_req_addr = old_pc;
  endtask

  // One clock: compare, edge, model update, memory response
  task automatic cycle();
    #1 compare();
    @(posedge clk);
    model_step();
    #1;
    imem_rsp_valid = dut_acc;
    imem_rsp_data  = dut_addr ^ 32'h0000_00A5;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    rst = 1'b1; imem_rdy = 1'b0; dec_ready = 1'b0; flush = 1'b0; flush_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_dec", inst_dec, NOP);
    check("rst_pc_dec", pc_dec, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Streaming with memory and decode always ready
    for (int i = 0; i < 20; i++) begin
      imem_rdy = 1'b1; dec_ready = 1'b1; flush = 1'b0;
      #1;
      if (i == 0) begin
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RV);
      end
      if (i == 1) check("second_addr", imem_addr, RV + 32'd4);
      if (i == 1) check("not_valid_yet", 32'(inst_valid), 32'd0);
      if (i == 2) begin
        check("first_valid", 32'(inst_valid), 32'd1);
        check("first_pc_dec", pc_dec, RV);
        check("first_inst", inst_dec, RV ^ 32'h0000_00A5);
      end
      if (i == 3) check("second_pc_dec", pc_dec, RV + 32'd4);
      cycle();
    end

    // Decode back-pressure: FIFO fills and requests stop
    for (int i = 0; i < 10; i++) begin
      dec_ready = 1'b0;
      #1;
      if (i == 9) begin
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_valid", 32'(inst_valid), 32'd1);
      end
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      dec_ready = 1'b1;
      cycle();
    end

    // Flush while a request is in flight
    flush = 1'b1; flush_pc = 32'h4000_0100;
    cycle();
    flush = 1'b0;
    for (int i = 1; i < 8; i++) begin
      #1;
      if (i == 1) check("flush_addr", imem_addr, 32'h4000_0100);
      if (i == 2) check("flush_gap", 32'(inst_valid), 32'd0);
      if (i == 3) begin
        check("flush_valid", 32'(inst_valid), 32'd1);
        check("flush_pc_dec", pc_dec, 32'h4000_0100);
      end
      cycle();
    end

    // Memory ready toggling every cycle
    for (int i = 0; i < 20; i++) begin
      imem_rdy = i[0];
      cycle();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      imem_rdy  = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      flush_pc  = 32'h4000_0000 | ($urandom & 32'h0000_0FFF);
      cycle();
    end

    // Fill the FIFO, then reset mid-cycle with a late response pending
    imem_rdy = 1'b1; dec_ready = 1'b0; flush = 1'b0;
    repeat (6) cycle();
    #1 check("full_valid", 32'(inst_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_inst", inst_dec, NOP);
    check("async_rst_pc_dec", pc_dec, 32'd0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; dec_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i == 0) check("restart_addr", imem_addr, RV);
      if (i == 2) check("restart_pc_dec", pc_dec, RV);
      cycle();
    end

`ifdef FETCH_PERF_CNT_EN
    // Memory stalled with decode ready and nothing buffered
    imem_rdy = 1'b0; dec_ready = 1'b1; flush = 1'b0;
    repeat (4) cycle();
    #1 check("perf_empty", 32'(inst_valid), 32'd0);
    snap = stall_cnt;
    repeat (5) cycle();
    #1 check("perf_delta", stall_cnt - snap, 32'd5);
`else
    snap = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ama_riscv_fetch.md
# ama_riscv_fetch

Instruction fetch unit feeding `inst_dec` to the decoder, i.e. the producer side of the decoder's instruction input. It owns the fetch PC, issues requests to the instruction memory, buffers returned instructions in a small FIFO, and presents them to decode through a valid/ready handshake. It also handles redirects (flushes) from the frontend control.

## Interface
- `RESET_VEC`, default `32'h4000_0000`: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries. Power of 2, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, word-aligned.
- `imem_rdy` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response valid. Asserted exactly 1 cycle after an accepted request.
- `imem_rsp_data` in 32: fetched instruction.
- `inst_dec` out 32: instruction to the decoder (`arch_width_t`).
- `pc_dec` out 32: PC of `inst_dec`.
- `inst_valid` out 1: `inst_dec`/`pc_dec` valid.
- `dec_ready` in 1: decoder consumes this cycle.
- `flush` in 1: redirect request.
- `flush_pc` in 32: redirect target.
- `stall_cnt` out 32: present only with `FETCH_PERF_CNT_EN`.

## Operation
- State:
  - `pc`: next fetch address.
  - FIFO of {inst, pc} entries, with `count`.
  - `inflight` flag.
  - `drop` flag.
- Request issue:
  - Issue condition: `imem_req = !flush && (count + inflight - pop) < FIFO_DEPTH`, where `pop = inst_valid && dec_ready`.
  - `imem_addr = pc`.
  - On `imem_req && imem_rdy`: `pc <= pc + 4`, `inflight <= 1`. Otherwise `inflight <= 0`.
- Response handling:
  - When `imem_rsp_valid && !drop`: push {`imem_rsp_data`, address of that request}.
  - The FIFO stores the request address alongside the data, so `pc_dec` is exact.
  - The credit rule guarantees a push never finds the FIFO full. A push into a full FIFO is a design error; it is flagged by an assertion and must not be reachable.
- Decode side:
  - `inst_valid = (count != 0)`.
  - `inst_dec`/`pc_dec` come from the FIFO head.
  - When the FIFO is empty: `inst_dec = 32'h0000_0013` (NOP), `pc_dec` holds its last value.
- Flush (highest priority):
  - In the flush cycle: FIFO cleared, `pc <= flush_pc`, no request issued.
  - `drop <= inflight`, so a response arriving next cycle is discarded. `drop` self-clears after one cycle.
  - Any pop in the flush cycle is still considered consumed by decode.
- Simultaneous push and pop: `count` unchanged, FIFO pointers both advance. Pointers wrap modulo `FIFO_DEPTH`.
- `flush_pc[1:0]` is ignored (forced to 0).

## Timing
- Reset values while `rst` is high (asynchronous):
  - `pc = RESET_VEC`, `count = 0`, `inflight = 0`, `drop = 0`.
  - `imem_req = 0`.
  - `inst_valid = 0`, `inst_dec = 32'h0000_0013`, `pc_dec = 0`.
  - `stall_cnt = 0`.
- First cycle after reset release: `imem_req = 1`, `imem_addr = RESET_VEC`.
- Latency:
  - Request accepted at cycle N, response at N+1.
  - Instruction visible (`inst_valid = 1`) at N+2.
- Throughput: 1 instr/cycle sustained when `imem_rdy = 1` and `dec_ready = 1`.
- Flush at cycle F:
  - Request for `flush_pc` at F+1.
  - `inst_valid` for `flush_pc` no earlier than F+3.
- `imem_rdy = 0`: request held, `imem_addr` stable, `pc` not advanced.
- Outputs to decode are registered (FIFO head). There is no combinational path from `imem_rsp_data` to `inst_dec`.
- Reset asserted mid-operation: all state returns to reset values immediately. A response arriving after reset release is ignored, because `inflight` was cleared.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds the `stall_cnt` output and a 32-bit counter.
  - The counter increments each cycle with `dec_ready && !inst_valid && !flush`.
  - Wraps at 2^32 and resets to 0.
- Not defined: no port, no counter logic. All other behaviour is identical.

## Test plan
- Reset release, `imem_rdy = 1`, `dec_ready = 1`, memory returns `addr ^ 32'hA5`:
  - `imem_addr` = 0x40000000, 0x40000004, …, one per cycle.
  - First `inst_valid` 2 cycles after release with `pc_dec = 0x40000000`.
  - Thereafter one instruction per cycle, in order.
- `dec_ready = 0` for 10 cycles:
  - `count` saturates at 2, with no push into a full FIFO.
  - `imem_req` drops to 0.
  - On `dec_ready = 1`, the stream resumes with no gap or duplicate PC.
- `flush` with `flush_pc = 0x40000100` while a request is in flight:
  - The stale response is dropped.
  - Next visible `pc_dec = 0x40000100`, no older PC appears afterwards.
- `imem_rdy` toggling 1/0 every cycle:
  - `imem_addr` stays stable while stalled.
  - `pc_dec` sequence stays contiguous (+4).
- `rst` asserted mid-stream with the FIFO full:
  - Outputs go to reset values asynchronously.
  - After release, the fetch restarts at `RESET_VEC`.
- With `FETCH_PERF_CNT_EN`: hold memory `imem_rdy = 0` for 5 cycles with `dec_ready = 1` and the FIFO empty -> `stall_cnt` increases by exactly 5.
